bitslice_alu_reg: RTL and testbench
===================================

Name: bitslice_alu_reg

Overview:
- Registered N-bit ALU built from a ripple chain of 1-bit slices.
- Each slice conditionally inverts its a/b bits, then computes NAND, XOR, NOR and full-adder sum in parallel.
- A 4:1 multiplexer in each slice picks the result using the two control bits.
- The block sits in the datapath between operand registers and the writeback stage; it samples operands on a valid strobe and presents a registered result one cycle later.

Parameters:
- WIDTH, 8, operand/result width in bits (≥1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands/controls valid this cycle; sampled on rising clk.
- s0  input  1  control bit 0: inverts operand a; LSB of op select.
- s1  input  1  control bit 1: inverts operand b; MSB of op select.
- a  input  WIDTH  operand a.
- b  input  WIDTH  operand b.
- cin  input  1  carry into bit 0 of the adder chain.
- result  output  WIDTH  registered ALU result.
- cout  output  1  registered carry out of bit WIDTH-1 of the adder chain.
- zero  output  1  registered flag, 1 when result == 0.
- out_valid  output  1  registered; high one cycle after an accepted in_valid.

Behaviour:
- Operand conditioning, per bit i:
  - ia[i] = a[i] XOR s0
  - ib[i] = b[i] XOR s1
- Per-slice candidate results, all computed every cycle:
  - nand_i = ~(ia & ib)
  - xor_i = ia ^ ib
  - nor_i = ~(ia | ib)
  - sum_i = ia ^ ib ^ c_i, with carry c_{i+1} = majority(ia, ib, c_i), c_0 = cin
- Mux select index = {s1,s0}:
  - 00 → nand
  - 01 → xor
  - 10 → nor
  - 11 → sum
- Resulting operations:
  - op 00 = NAND(a,b)
  - op 01 = XNOR(a,b)
  - op 10 = ~a & b
  - op 11 = ~a + ~b + cin (mod 2^WIDTH)
- cout is always the adder-chain carry c_WIDTH, regardless of op; it is meaningful only for op 11 but must still match the formula for every op.
- Timing:
  - Combinational core; one register stage.
  - On a rising clk with in_valid=1: result, cout and zero load the new values, and out_valid goes 1.
  - On a rising clk with in_valid=0: out_valid goes 0; result, cout and zero hold their previous values.
- Latency is exactly 1 cycle. Back-to-back in_valid gives one result per cycle; there is no backpressure.
- Reset: asserting reset immediately, without waiting for a clock edge, forces result=0, cout=0, zero=0 and out_valid=0. Any operation in flight is discarded. The first edge after deassertion behaves normally.
- Width rules:
  - Sum overflow past WIDTH bits is dropped from result and reported only in cout.
  - There is no signed-overflow flag.
- zero is computed from the combinational result before registering, so it is always consistent with the registered result.

Decomposition:
- Shared package alu_pkg holds:
  - op encoding constants OP_NAND=2'b00, OP_XNOR=2'b01, OP_ANDN=2'b10, OP_ADDINV=2'b11
  - the default WIDTH constant
- Sub-module alu_bit_slice: inputs a, b, s0, s1, c_in; outputs res, c_out. It instantiates one fulladder (sum, carry, a, b, c) and one multiplexer (out, s0, s1, in0..in3).
- The top level generates WIDTH slices in a ripple chain, plus the output and flag registers.

Test Plan:
All cases use WIDTH=8.
1. Reset while out_valid=1 and result nonzero → result, cout, zero and out_valid read 0 immediately, before the next clk edge.
2. s1s0=00, a=0xF0, b=0xCC, cin=0, in_valid=1 → next cycle result=0x3F, zero=0, out_valid=1. Repeat with a=b=0xFF → result=0x00, zero=1.
3. s1s0=01, a=0xF0, b=0xCC → result=0xC3. Then s1s0=10, same operands → result=0x0C.
4. s1s0=11, a=0x00, b=0x00, cin=1 → result=0xFF, cout=1. Then a=0xFE, b=0xFF, cin=0 → result=0x01, cout=0. Then a=0x0F, b=0xF0, cin=0 → result=0xFF, cout=0.
5. Hold and back-to-back:
   - Three consecutive valid ops → three consecutive results, each one cycle later.
   - in_valid=0 for 2 cycles → out_valid=0 and result unchanged.
6. Random sweep of 1000 vectors over all ops and cin → matches the formulas above for result, cout and zero.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants for the bit-slice ALU
//
// Purpose: op-select encodings ({s1,s0}) and the default datapath width
//          used by the bit-slice ALU modules.
// Ports:   none (package).
package alu_pkg;

   localparam logic [1:0] OP_NAND   = 2'b00;
   localparam logic [1:0] OP_XNOR   = 2'b01;
   localparam logic [1:0] OP_ANDN   = 2'b10;
   localparam logic [1:0] OP_ADDINV = 2'b11;

   localparam int ALU_WIDTH = 8;

endpackage

// File: rtl/alu_bit_slice.sv
// rtl/alu_bit_slice.sv - one bit of the ripple ALU
//
// Purpose: conditions the operand bits with the control bits, forms
//          NAND/XOR/NOR/sum in parallel and muxes one out.
// Ports:   a, b   - operand bits
//          s0, s1 - control bits (invert a / invert b, op select)
//          c_in   - carry from the previous slice
//          res    - selected slice result
//          c_out  - carry to the next slice
module alu_bit_slice (
   input  logic a,
   input  logic b,
   input  logic s0,
   input  logic s1,
   input  logic c_in,
   output logic res,
   output logic c_out
);

   logic w_ia;
   logic w_ib;
   logic w_nand;
   logic w_xor;
   logic w_nor;
   logic w_sum;

   // Inverting the operands with the same bits that select the op is what
   // turns the raw NAND/XOR/NOR/ADD gates into NAND/XNOR/ANDN/ADDINV.
   assign w_ia   = a ^ s0;
   assign w_ib   = b ^ s1;
   assign w_nand = ~(w_ia & w_ib);
   assign w_xor  = w_ia ^ w_ib;
   assign w_nor  = ~(w_ia | w_ib);

   fulladder u_fa (
      .sum   (w_sum),
      .carry (c_out),
      .a     (w_ia),
      .b     (w_ib),
      .c     (c_in)
   );

   multiplexer u_mux (
      .out (res),
      .s0  (s0),
      .s1  (s1),
      .in0 (w_nand),
      .in1 (w_xor),
      .in2 (w_nor),
      .in3 (w_sum)
   );

endmodule

// File: rtl/fulladder.sv
// rtl/fulladder.sv - 1-bit full adder
//
// Purpose: sum/carry of three input bits.
// Ports:   sum   - a ^ b ^ c
//          carry - majority(a, b, c)
//          a, b  - addend bits
//          c     - carry in
module fulladder (
   output logic sum,
   output logic carry,
   input  logic a,
   input  logic b,
   input  logic c
);

   assign sum   = a ^ b ^ c;
   assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/multiplexer.sv
// rtl/multiplexer.sv - 4:1 single-bit multiplexer indexed by {s1,s0}
//
// Purpose: picks one of four slice candidates using the op-select bits.
// Ports:   out     - selected input
//          s0, s1  - select bits, index = {s1,s0}
//          in0..3  - candidates (nand, xor, nor, sum)
module multiplexer
   import alu_pkg::*;
(
   output logic out,
   input  logic s0,
   input  logic s1,
   input  logic in0,
   input  logic in1,
   input  logic in2,
   input  logic in3
);

   always_comb begin
      out = in0;
      case ({s1, s0})
         OP_NAND:   out = in0;
         OP_XNOR:   out = in1;
         OP_ANDN:   out = in2;
         OP_ADDINV: out = in3;
         default:   out = in0;
      endcase
   end

endmodule

// File: rtl/bitslice_alu_reg.sv
// rtl/bitslice_alu_reg.sv - registered N-bit ripple ALU built from bit slices
//
// Purpose: WIDTH-bit ALU (NAND, XNOR, ~a&b, ~a+~b+cin) with one output
//          register stage; one result per accepted in_valid, no backpressure.
// Ports:   clk       - rising-edge clock
//          reset     - asynchronous active-high reset
//          in_valid  - operands/controls valid this cycle
//          s0, s1    - control bits; op = {s1,s0}
//          a, b      - operands
//          cin       - carry into bit 0
//          result    - registered ALU result
//          cout      - registered carry out of the chain (every op)
//          zero      - registered result==0 flag
//          out_valid - high one cycle after an accepted in_valid
module bitslice_alu_reg
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             s0,
   input  logic             s1,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             zero,
   output logic             out_valid
);

   logic [WIDTH:0]   w_carry;
   logic [WIDTH-1:0] w_result;
   logic             w_zero;

   logic [WIDTH-1:0] r_result;
   logic             r_cout;
   logic             r_zero;
   logic             r_out_valid;

   assign w_carry[0] = cin;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_slice
         alu_bit_slice u_slice (
            .a     (a[gi]),
            .b     (b[gi]),
            .s0    (s0),
            .s1    (s1),
            .c_in  (w_carry[gi]),
            .res   (w_result[gi]),
            .c_out (w_carry[gi+1])
         );
      end
   endgenerate

   // Flag is taken from the combinational result so it loads in the same
   // edge as the value it describes.
   assign w_zero = (w_result == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_result    <= '0;
         r_cout      <= 1'b0;
         r_zero      <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_result <= w_result;
            r_cout   <= w_carry[WIDTH];
            r_zero   <= w_zero;
         end
      end
   end

   assign result    = r_result;
   assign cout      = r_cout;
   assign zero      = r_zero;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_bitslice_alu_reg.sv
// tb/tb_bitslice_alu_reg.sv - self-checking bench for bitslice_alu_reg
module tb_bitslice_alu_reg;

   localparam int W = 8;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         s0;
   logic         s1;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic [W-1:0] result;
   logic         cout;
   logic         zero;
   logic         out_valid;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 0;

   logic [W-1:0] exp_result;
   logic         exp_cout;
   logic         exp_zero;
   logic         exp_valid;

   bitslice_alu_reg #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .s0        (s0),
      .s1        (s1),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .result    (result),
      .cout      (cout),
      .zero      (zero),
      .out_valid (out_valid)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // Operation-level model: {cout, result}
   function automatic logic [W:0] model(input logic [1:0] op, input logic [W-1:0] ta,
                                        input logic [W-1:0] tb, input logic tc);
      logic [W-1:0] r;
      logic [W-1:0] ma;
      logic [W-1:0] mb;
      int unsigned  tot;
      ma  = op[0] ? ~ta : ta;
      mb  = op[1] ? ~tb : tb;
      tot = int'(ma) + int'(mb) + int'(tc);
      case (op)
         2'b00:   r = ~(ta & tb);
         2'b01:   r = ~(ta ^ tb);
         2'b10:   r = ~ta & tb;
         default: r = W'(int'(~ta) + int'(~tb) + int'(tc));
      endcase
      return {tot >= (1 << W), r};
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         exp_result <= '0;
         exp_cout   <= 1'b0;
         exp_zero   <= 1'b0;
         exp_valid  <= 1'b0;
      end else begin
         exp_valid <= in_valid;
         if (in_valid) begin
            logic [W:0] m;
            m = model({s1, s0}, a, b, cin);
            exp_result <= m[W-1:0];
            exp_cout   <= m[W];
            exp_zero   <= (m[W-1:0] == '0);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model_out_valid", 32'(out_valid), 32'(exp_valid));
         chk("model_result",    32'(result),    32'(exp_result));
         chk("model_cout",      32'(cout),      32'(exp_cout));
         chk("model_zero",      32'(zero),      32'(exp_zero));
      end
   end

   task automatic drive(input logic [1:0] op, input logic [W-1:0] ta,
                        input logic [W-1:0] tb, input logic tc);
      @(negedge clk);
      in_valid = 1'b1;
      {s1, s0} = op;
      a        = ta;
      b        = tb;
      cin      = tc;
   endtask

   task automatic op_check(input string name, input logic [1:0] op, input logic [W-1:0] ta,
                           input logic [W-1:0] tb, input logic tc, input logic [W-1:0] er,
                           input logic ec, input logic ez);
      drive(op, ta, tb, tc);
      @(negedge clk);
      in_valid = 1'b0;
      chk({name, "_valid"},  32'(out_valid), 32'd1);
      chk({name, "_result"}, 32'(result),    32'(er));
      chk({name, "_cout"},   32'(cout),      32'(ec));
      chk({name, "_zero"},   32'(zero),      32'(ez));
   endtask

   logic [W:0]   m;
   logic [1:0]   seq_op [3];
   logic [W-1:0] seq_a  [3];
   logic [W-1:0] seq_b  [3];
   logic [W-1:0] seq_r  [3];

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      s0 = 0; s1 = 0; a = '0; b = '0; cin = 0;

      // Pin the model with hand-computed values
      m = model(2'b11, 8'h00, 8'h00, 1'b1); chk("pin_add0", 32'(m), 32'h1FF);
      m = model(2'b11, 8'hFE, 8'hFF, 1'b0); chk("pin_add1", 32'(m), 32'h001);
      m = model(2'b01, 8'hF0, 8'hCC, 1'b0); chk("pin_xnor", 32'(m), 32'h0C3);
      m = model(2'b10, 8'hF0, 8'hCC, 1'b0); chk("pin_andn", 32'(m), 32'h10C);

      repeat (2) @(negedge clk);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_valid",  32'(out_valid), 32'd0);
      chk("rst_zero",   32'(zero), 32'd0);
      chk("rst_cout",   32'(cout), 32'd0);
      reset  = 1'b0;
      cmp_en = 1;

      op_check("nand",     2'b00, 8'hF0, 8'hCC, 1'b0, 8'h3F, 1'b1, 1'b0);
      op_check("nand_ff",  2'b00, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b1);
      op_check("xnor",     2'b01, 8'hF0, 8'hCC, 1'b0, 8'hC3, 1'b0, 1'b0);
      op_check("andn",     2'b10, 8'hF0, 8'hCC, 1'b0, 8'h0C, 1'b1, 1'b0);
      op_check("add_00",   2'b11, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
      op_check("add_fe",   2'b11, 8'hFE, 8'hFF, 1'b0, 8'h01, 1'b0, 1'b0);
      op_check("add_0f",   2'b11, 8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0, 1'b0);

      // Asynchronous reset with a live nonzero result
      drive(2'b00, 8'hF0, 8'hCC, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("pre_rst_valid",  32'(out_valid), 32'd1);
      chk("pre_rst_result", 32'(result), 32'h3F);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_result", 32'(result), 32'd0);
      chk("async_rst_cout",   32'(cout), 32'd0);
      chk("async_rst_zero",   32'(zero), 32'd0);
      chk("async_rst_valid",  32'(out_valid), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Back-to-back then hold
      seq_op[0] = 2'b00; seq_a[0] = 8'hA5; seq_b[0] = 8'h0F; seq_r[0] = 8'hFA;
      seq_op[1] = 2'b01; seq_a[1] = 8'hA5; seq_b[1] = 8'h0F; seq_r[1] = 8'h55;
      seq_op[2] = 2'b11; seq_a[2] = 8'h01; seq_b[2] = 8'h01; seq_r[2] = 8'hFC;
      drive(seq_op[0], seq_a[0], seq_b[0], 1'b0);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         chk("b2b_valid",  32'(out_valid), 32'd1);
         chk("b2b_result", 32'(result), 32'(seq_r[i-1]));
         if (i < 3) begin
            {s1, s0} = seq_op[i]; a = seq_a[i]; b = seq_b[i]; cin = 1'b0;
         end else begin
            in_valid = 1'b0;
         end
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("hold_valid",  32'(out_valid), 32'd0);
         chk("hold_result", 32'(result), 32'hFC);
      end

      // Random sweep checked by the model compare process
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         in_valid = ($urandom_range(0, 7) != 0);
         {s1, s0} = 2'($urandom_range(0, 3));
         a        = W'($urandom);
         b        = W'($urandom);
         cin      = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      cmp_en = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
